// File: rtl/vospi_packet_parser.sv
// VoSPI packet parser: turns the byte stream from vospi_master into pixels
// tagged with column/line, with frame start/end markers and discard pulses.
// Optional line-sequence check is built only when VOSPI_PARSER_SEQ_CHECK_EN
// is defined; otherwise seq_err_o is tied low.
module vospi_packet_parser #(
  parameter int unsigned packet_bytes_p  = 164,
  parameter int unsigned frame_packets_p = 60,
  parameter int unsigned pixel_bytes_p   = 2,
  localparam int unsigned line_width_p   = (packet_bytes_p - 4) / pixel_bytes_p,
  localparam int unsigned x_w_lp         = $clog2(line_width_p),
  localparam int unsigned y_w_lp         = $clog2(frame_packets_p)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [7:0]                 data_i,
  input  logic                       valid_i,
  output logic [8*pixel_bytes_p-1:0] pixel_o,
  output logic [x_w_lp-1:0]          x_o,
  output logic [y_w_lp-1:0]          y_o,
  output logic                       valid_o,
  output logic                       sof_o,
  output logic                       eof_o,
  output logic                       discard_o,
  output logic                       seq_err_o
);

  localparam int unsigned payload_bytes_lp = packet_bytes_p - 4;
  localparam int unsigned bcnt_w_lp = $clog2(payload_bytes_lp);
  localparam int unsigned pcnt_w_lp = (pixel_bytes_p > 1) ? $clog2(pixel_bytes_p) : 1;
  localparam int unsigned pix_w_lp  = 8 * pixel_bytes_p;

  localparam logic [bcnt_w_lp-1:0] last_byte_lp   = bcnt_w_lp'(payload_bytes_lp - 1);
  localparam logic [pcnt_w_lp-1:0] last_pbyte_lp  = pcnt_w_lp'(pixel_bytes_p - 1);
  localparam logic [x_w_lp-1:0]    last_x_lp      = x_w_lp'(line_width_p - 1);
  localparam logic [11:0]          frame_lines_lp = 12'(frame_packets_p);
  localparam logic [11:0]          last_line_lp   = 12'(frame_packets_p - 1);

  localparam logic [2:0] st_id_hi   = 3'd0;
  localparam logic [2:0] st_id_lo   = 3'd1;
  localparam logic [2:0] st_crc_hi  = 3'd2;
  localparam logic [2:0] st_crc_lo  = 3'd3;
  localparam logic [2:0] st_payload = 3'd4;
  localparam logic [2:0] st_skip    = 3'd5;

  logic [2:0]           state_q, state_d;
  logic [3:0]           id_hi_q;
  logic [11:0]          line_q;
  logic [bcnt_w_lp-1:0] byte_cnt_q;
  logic [pcnt_w_lp-1:0] pbyte_cnt_q;
  logic [x_w_lp-1:0]    x_cnt_q;
  logic [pix_w_lp-1:0]  pix_sr_q;

  logic [pix_w_lp-1:0]  pixel_q;
  logic [x_w_lp-1:0]    x_q;
  logic [y_w_lp-1:0]    y_q;
  logic                 valid_q, sof_q, eof_q, discard_q;

  logic                 hdr_discard, hdr_oor, last_byte;
  logic [pix_w_lp+7:0]  pix_wide;
  logic [pix_w_lp-1:0]  pix_next;

  // Header classification, payload shift value and next FSM state.
  always_comb begin
    hdr_discard = (id_hi_q == 4'hF);
    hdr_oor     = (line_q >= frame_lines_lp);
    last_byte   = (byte_cnt_q == last_byte_lp);
    pix_wide    = {pix_sr_q, data_i};
    pix_next    = pix_wide[pix_w_lp-1:0];
    state_d     = state_q;
    if (valid_i) begin
      case (state_q)
        st_id_hi:   state_d = st_id_lo;
        st_id_lo:   state_d = st_crc_hi;
        st_crc_hi:  state_d = st_crc_lo;
        st_crc_lo:  state_d = (hdr_discard || hdr_oor) ? st_skip : st_payload;
        st_payload,
        st_skip:    state_d = last_byte ? st_id_hi : state_q;
        default:    state_d = st_id_hi;
      endcase
    end
  end

  // Parser state, counters, pixel assembly and registered outputs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= st_id_hi;
      id_hi_q     <= '0;
      line_q      <= '0;
      byte_cnt_q  <= '0;
      pbyte_cnt_q <= '0;
      x_cnt_q     <= '0;
      pix_sr_q    <= '0;
      pixel_q     <= '0;
      x_q         <= '0;
      y_q         <= '0;
      valid_q     <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      discard_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      valid_q   <= 1'b0;
      sof_q     <= 1'b0;
      eof_q     <= 1'b0;
      discard_q <= 1'b0;
      if (valid_i) begin
        case (state_q)
          st_id_hi: id_hi_q <= data_i[3:0];
          st_id_lo: line_q  <= {id_hi_q, data_i};
          st_crc_lo: begin
            byte_cnt_q  <= '0;
            pbyte_cnt_q <= '0;
            x_cnt_q     <= '0;
            discard_q   <= hdr_discard;
          end
          st_payload: begin
            byte_cnt_q <= byte_cnt_q + 1'b1;
            pix_sr_q   <= pix_next;
            if (pbyte_cnt_q == last_pbyte_lp) begin
              pbyte_cnt_q <= '0;
              x_cnt_q     <= x_cnt_q + 1'b1;
              pixel_q     <= pix_next;
              x_q         <= x_cnt_q;
              y_q         <= line_q[y_w_lp-1:0];
              valid_q     <= 1'b1;
              sof_q       <= (x_cnt_q == '0) && (line_q == '0);
              eof_q       <= (x_cnt_q == last_x_lp) && (line_q == last_line_lp);
            end else begin
              pbyte_cnt_q <= pbyte_cnt_q + 1'b1;
            end
          end
          st_skip: byte_cnt_q <= byte_cnt_q + 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign pixel_o   = pixel_q;
  assign x_o       = x_q;
  assign y_o       = y_q;
  assign valid_o   = valid_q;
  assign sof_o     = sof_q;
  assign eof_o     = eof_q;
  assign discard_o = discard_q;

`ifdef VOSPI_PARSER_SEQ_CHECK_EN
  logic [y_w_lp-1:0] exp_line_q;
  logic              seq_err_q;
  logic              hdr_accept;

  // Only headers that lead to a parsed payload take part in the check.
  assign hdr_accept = valid_i && (state_q == st_crc_lo) && !hdr_discard && !hdr_oor;

  // Track the expected next line; line 0 always resynchronises.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      exp_line_q <= '0;
      seq_err_q  <= 1'b0;
    end else if (hdr_accept) begin
      if ((line_q != '0) && (line_q != 12'(exp_line_q))) begin
        seq_err_q <= 1'b1;
      end
      exp_line_q <= (line_q == last_line_lp) ? '0 : line_q[y_w_lp-1:0] + 1'b1;
    end
  end

  assign seq_err_o = seq_err_q;
`else
  assign seq_err_o = 1'b0;
`endif

endmodule
